// File: rtl/stepper_motion_ctrl.sv
// Single-axis stepper move engine: accepts relative moves, runs a linear trapezoidal
// speed ramp in one of three excitation modes, and drives the L298N IN1..IN4 pins.
module stepper_motion_ctrl #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 24,
  parameter int POS_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    hold_en,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic [CNT_W-1:0]        cmd_start_period,
  input  logic [CNT_W-1:0]        cmd_min_period,
  input  logic [CNT_W-1:0]        cmd_accel_dec,
  input  logic                    abort,
  input  logic                    pos_clr,
  output logic [3:0]              coil_out,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic signed [POS_W-1:0] position
);

  typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

  state_t            state;
  logic [2:0]        phase_idx;
  logic              half_q, dir_q;
  logic [STEP_W-1:0] remaining, ramp_cnt;
  logic [CNT_W-1:0]  period, start_q, min_q, dec_q, cnt;

  logic              in_move, tick, finish, take, go_decel;
  logic [2:0]        accept_idx, step_idx;
  logic [CNT_W-1:0]  start_eff, min_clamp, min_eff, period_dn, period_up;
  logic [CNT_W:0]    diff, sum;
  logic [STEP_W-1:0] rem_next, ramp_next;

  function automatic logic [3:0] phase_lut(input logic [2:0] idx);
    case (idx)
      3'd0: phase_lut = 4'b1000;
      3'd1: phase_lut = 4'b1010;
      3'd2: phase_lut = 4'b0010;
      3'd3: phase_lut = 4'b0110;
      3'd4: phase_lut = 4'b0100;
      3'd5: phase_lut = 4'b0101;
      3'd6: phase_lut = 4'b0001;
      3'd7: phase_lut = 4'b1001;
    endcase
  endfunction

  assign in_move   = (state == S_ACCEL) || (state == S_CRUISE) || (state == S_DECEL);
  assign cmd_ready = en && ((state == S_IDLE) || (state == S_HOLD));
  assign tick      = in_move && (cnt == period - CNT_W'(1));
  assign finish    = tick && (remaining == STEP_W'(1));
  // A completing step beats abort; any other step is dropped when abort is seen.
  assign take      = tick && (finish || !abort);

  always_comb begin
    // NOTE: defaults come first so every path assigns the signal and no latch is inferred.
    accept_idx = phase_idx;
    case (mode)
      2'd0:    accept_idx = {phase_idx[2:1], 1'b0};
      2'd1:    accept_idx = {phase_idx[2:1], 1'b1};
      default: ;
    endcase

    start_eff = (cmd_start_period < MIN_PERIOD) ? MIN_PERIOD : cmd_start_period;
    min_clamp = (cmd_min_period < MIN_PERIOD) ? MIN_PERIOD : cmd_min_period;
    min_eff   = (min_clamp > start_eff) ? start_eff : min_clamp;

    step_idx = dir_q ? phase_idx - (half_q ? 3'd1 : 3'd2)
                     : phase_idx + (half_q ? 3'd1 : 3'd2);

    // Extra top bit catches borrow/carry so the ramp saturates instead of wrapping.
    diff      = {1'b0, period} - {1'b0, dec_q};
    sum       = {1'b0, period} + {1'b0, dec_q};
    period_dn = (diff[CNT_W] || (diff[CNT_W-1:0] < min_q)) ? min_q : diff[CNT_W-1:0];
    period_up = (sum[CNT_W] || (sum[CNT_W-1:0] > start_q)) ? start_q : sum[CNT_W-1:0];

    rem_next  = remaining - STEP_W'(1);
    ramp_next = ramp_cnt + STEP_W'(state == S_ACCEL);
    go_decel  = (state != S_DECEL) && (rem_next <= ramp_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      phase_idx <= '0;
      half_q    <= 1'b0;
      dir_q     <= 1'b0;
      remaining <= '0;
      ramp_cnt  <= '0;
      period    <= '0;
      start_q   <= '0;
      min_q     <= '0;
      dec_q     <= '0;
      cnt       <= '0;
      coil_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      position  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every branch sees pre-edge values.
      done <= 1'b0;
      if (!en) begin
        if (in_move) begin
          aborted <= 1'b1;
          done    <= 1'b1;
        end
        state    <= S_IDLE;
        busy     <= 1'b0;
        coil_out <= '0;
      end else begin
        case (state)
          S_IDLE, S_HOLD: begin
            if (cmd_valid) begin
              half_q    <= mode[1];
              dir_q     <= cmd_dir;
              start_q   <= start_eff;
              min_q     <= min_eff;
              dec_q     <= cmd_accel_dec;
              period    <= start_eff;
              cnt       <= '0;
              ramp_cnt  <= '0;
              remaining <= cmd_steps;
              aborted   <= 1'b0;
              if (cmd_steps == '0) begin
                done <= 1'b1;
              end else begin
                phase_idx <= accept_idx;
                coil_out  <= phase_lut(accept_idx);
                state     <= S_ACCEL;
                busy      <= 1'b1;
              end
            end
          end
          S_ACCEL, S_CRUISE, S_DECEL: begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (take) begin
              phase_idx <= step_idx;
              remaining <= rem_next;
              position  <= dir_q ? position - POS_ONE : position + POS_ONE;
            end
            if (finish || (abort && !tick) || (abort && tick && !finish)) begin
              done     <= 1'b1;
              aborted  <= !finish;
              busy     <= 1'b0;
              state    <= hold_en ? S_HOLD : S_IDLE;
              coil_out <= hold_en ? phase_lut(finish ? step_idx : phase_idx) : 4'b0000;
            end else if (tick) begin
              coil_out <= phase_lut(step_idx);
              ramp_cnt <= ramp_next;
              if (go_decel || (state == S_DECEL)) begin
                state  <= S_DECEL;
                period <= period_up;
              end else if (state == S_ACCEL) begin
                period <= period_dn;
                if (period_dn == min_q) state <= S_CRUISE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      if (pos_clr) position <= '0;
    end
  end

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Bench for stepper_motion_ctrl: directed moves then random moves, each checked
// cycle by cycle against a step-interval/phase model built from the ramp rules.
module tb_stepper_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, hold_en, cmd_valid, cmd_dir, abort, pos_clr;
  logic [1:0]  mode;
  logic [23:0] cmd_steps;
  logic [31:0] cmd_start_period, cmd_min_period, cmd_accel_dec;
  logic        cmd_ready, busy, done, aborted;
  logic [3:0]  coil_out;
  logic signed [31:0] position;

  int n_cmp = 0;
  int n_bad = 0;
  int midx  = 0;
  int mpos  = 0;
  int prof[$];
  logic [3:0] phase_tab [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                                4'b0100, 4'b0101, 4'b0001, 4'b1001};

  stepper_motion_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .mode             (mode),
    .hold_en          (hold_en),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_dir          (cmd_dir),
    .cmd_steps        (cmd_steps),
    .cmd_start_period (cmd_start_period),
    .cmd_min_period   (cmd_min_period),
    .cmd_accel_dec    (cmd_accel_dec),
    .abort            (abort),
    .pos_clr          (pos_clr),
    .coil_out         (coil_out),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .position         (position)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag);
    logic [31:0] want;
    want = 32'(mpos);
    check(tag, {32'd0, position}, {32'd0, want});
  endtask

  // Wait (in clocks) before each step: the first is the start period, and every
  // completed step adjusts the wait for the next one by the ramp rules.
  task automatic build_profile(input int steps, input int sp, input int mp, input int dec);
    int p, ramp, rem;
    bit cruising, decel;
    prof.delete();
    p = sp; ramp = 0; rem = steps; cruising = 0; decel = 0;
    for (int k = 0; k < steps; k++) begin
      prof.push_back(p);
      rem--;
      if (!cruising && !decel) ramp++;
      if (decel || rem <= ramp) begin
        decel = 1;
        p = (p + dec > sp) ? sp : p + dec;
      end else if (!cruising) begin
        p = (p - dec < mp) ? mp : p - dec;
        cruising = (p == mp);
      end
    end
  endtask

  task automatic run_move(input int md, input int dr, input int steps, input int sp,
                          input int mp, input int dec, input int hold, input int cut_after,
                          input int cut_en, input int clr_step, input int abort_final);
    int s_eff, m_eff, d;
    logic [3:0] prev;
    s_eff = (sp < 2) ? 2 : sp;
    m_eff = (mp < 2) ? 2 : mp;
    if (m_eff > s_eff) m_eff = s_eff;
    build_profile(steps, s_eff, m_eff, dec);
    d = (md >= 2) ? 1 : 2;
    if (dr != 0) d = -d;

    check("ready_before_accept", {63'd0, cmd_ready}, 64'd1);
    mode = 2'(md); cmd_dir = (dr != 0); hold_en = (hold != 0);
    cmd_steps = 24'(steps); cmd_start_period = 32'(sp);
    cmd_min_period = 32'(mp); cmd_accel_dec = 32'(dec);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    // Command fields must be latched at accept; scramble them afterwards.
    mode = 2'($urandom); cmd_dir = ~cmd_dir; cmd_steps = 24'($urandom);
    cmd_start_period = $urandom; cmd_min_period = $urandom; cmd_accel_dec = $urandom;

    if (steps == 0) begin
      check("zero_done", {63'd0, done}, 64'd1);
      check("zero_aborted", {63'd0, aborted}, 64'd0);
      check("zero_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("zero_done_clear", {63'd0, done}, 64'd0);
      return;
    end

    if (md == 0) midx = midx & 6;
    else if (md == 1) midx = midx | 1;
    prev = phase_tab[midx];
    check("start_coil", {60'd0, coil_out}, {60'd0, prev});
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_ready", {63'd0, cmd_ready}, 64'd0);
    check("start_aborted", {63'd0, aborted}, 64'd0);

    for (int k = 1; k <= steps; k++) begin
      if (cut_after == k - 1) begin
        if (cut_en != 0) en = 1'b0; else abort = 1'b1;
        @(negedge clk);
        check("cut_done", {63'd0, done}, 64'd1);
        check("cut_aborted", {63'd0, aborted}, 64'd1);
        check("cut_busy", {63'd0, busy}, 64'd0);
        check_pos("cut_pos");
        check("cut_coil", {60'd0, coil_out},
              {60'd0, ((cut_en == 0) && (hold != 0)) ? prev : 4'b0000});
        if (cut_en != 0) check("cut_ready_en_low", {63'd0, cmd_ready}, 64'd0);
        en = 1'b1; abort = 1'b0;
        @(negedge clk);
        check("cut_done_clear", {63'd0, done}, 64'd0);
        return;
      end
      for (int j = 1; j < prof[k-1]; j++) begin
        @(negedge clk);
        check($sformatf("wait_coil s%0d c%0d", k, j), {60'd0, coil_out}, {60'd0, prev});
        check($sformatf("wait_done s%0d c%0d", k, j), {63'd0, done}, 64'd0);
      end
      if (k == clr_step) pos_clr = 1'b1;
      if ((abort_final != 0) && (k == steps)) abort = 1'b1;
      @(negedge clk);
      pos_clr = 1'b0; abort = 1'b0;
      midx = (midx + 8 + d) % 8;
      mpos = (k == clr_step) ? 0 : mpos + ((dr != 0) ? -1 : 1);
      prev = phase_tab[midx];
      check_pos($sformatf("step_pos s%0d", k));
      if (k == steps) begin
        check("end_coil", {60'd0, coil_out}, {60'd0, (hold != 0) ? prev : 4'b0000});
        check("end_done", {63'd0, done}, 64'd1);
        check("end_busy", {63'd0, busy}, 64'd0);
        check("end_aborted", {63'd0, aborted}, 64'd0);
        @(negedge clk);
        check("end_done_clear", {63'd0, done}, 64'd0);
      end else begin
        check($sformatf("step_coil s%0d", k), {60'd0, coil_out}, {60'd0, prev});
        check($sformatf("step_busy s%0d", k), {63'd0, busy}, 64'd1);
      end
    end
  endtask

  task automatic clear_pos();
    pos_clr = 1'b1;
    @(negedge clk);
    pos_clr = 1'b0;
    mpos = 0;
    check_pos("pos_clr_idle");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coil"}, {60'd0, coil_out}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_aborted"}, {63'd0, aborted}, 64'd0);
    check_pos({tag, "_pos"});
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; hold_en = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0;
    abort = 1'b0; pos_clr = 1'b0; mode = 2'd0; cmd_steps = '0;
    cmd_start_period = '0; cmd_min_period = '0; cmd_accel_dec = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_ready", {63'd0, cmd_ready}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    run_move(2, 0, 8, 4, 4, 0, 1, -1, 0, 0, 0);     // half-step CW, constant speed
    clear_pos();
    check("hold_coil_idle", {60'd0, coil_out}, {60'd0, phase_tab[midx]});
    run_move(0, 1, 3, 10, 10, 0, 0, -1, 0, 0, 0);   // wave CCW
    run_move(2, 0, 10, 10, 4, 2, 0, -1, 0, 0, 0);   // full trapezoid
    run_move(3, 1, 3, 10, 2, 2, 1, -1, 0, 0, 0);    // triangle, reserved mode
    run_move(1, 0, 4, 1, 7, 3, 0, -1, 0, 2, 0);     // clamped periods, pos_clr on a step
    clear_pos();
    run_move(2, 0, 20, 4, 4, 0, 1, 5, 0, 0, 0);     // abort after 5 steps
    run_move(2, 0, 0, 4, 4, 0, 1, -1, 0, 0, 0);     // zero-step command from HOLD
    check("hold_after_zero", {60'd0, coil_out}, {60'd0, phase_tab[midx]});
    run_move(0, 0, 3, 3, 3, 0, 0, -1, 0, 0, 1);     // abort on the final step
    run_move(2, 1, 10, 5, 3, 1, 1, 3, 1, 0, 0);     // en drop mid-move

    // Asynchronous reset in the middle of a move.
    mode = 2'd2; hold_en = 1'b1; cmd_dir = 1'b0; cmd_steps = 24'd10;
    cmd_start_period = 32'd4; cmd_min_period = 32'd4; cmd_accel_dec = 32'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    #1 rst = 1'b1;
    #1;
    midx = 0; mpos = 0;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 16; r++) begin
      int md, dr, st, sp, mp, dc, hd, cut, cen;
      md  = int'($urandom_range(0, 3));
      dr  = int'($urandom_range(0, 1));
      st  = int'($urandom_range(0, 12));
      sp  = int'($urandom_range(0, 9));
      mp  = int'($urandom_range(0, 9));
      dc  = int'($urandom_range(0, 4));
      hd  = int'($urandom_range(0, 1));
      cen = int'($urandom_range(0, 1));
      cut = -1;
      if ((st > 0) && ($urandom_range(0, 3) == 0)) cut = int'($urandom_range(0, st - 1));
      run_move(md, dr, st, sp, mp, dc, hd, cut, cen, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
